fb_write_arbiter: RTL and testbench

Shares the single frame-buffer pixel write port (`mem_px_addr`/`mem_px_data`/`px_wr`) between the game-object drawers (paddle, ball, status marker) and a built-in rectangular-run fill engine used to clear rows or the whole screen. It sits between the game FSMs and the frame-buffer RAM write port, accepting one pixel write per clock. Requester arbitration is round-robin. A fill locks the port until the fill completes.

---
 rtl/fb_write_arbiter.sv | 133 +++++++++++++
 tb/tb_fb_write_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// Frame-buffer pixel write-port arbiter: round-robin pixel requesters plus a
// run-fill engine that owns the port from the accepted start to its last write.
module fb_write_arbiter #(
  parameter int AW   = 15,
  parameter int DW   = 3,
  parameter int NREQ = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  input  logic               fill_start,
  input  logic [AW-1:0]      fill_base,
  input  logic [AW-1:0]      fill_len,
  input  logic [DW-1:0]      fill_color,
  output logic               fill_busy,
  output logic               fill_done,
  output logic [AW-1:0]      mem_px_addr,
  output logic [DW-1:0]      mem_px_data,
  output logic               px_wr
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {IDLE, FILL} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant_idx;
  logic          grant_vld;
  logic          fill_go;
  logic          arb_en;
  logic [AW-1:0] grant_addr;
  logic [DW-1:0] grant_data;
  logic [AW-1:0] cnt_addr;
  logic [AW-1:0] remaining;
  logic [DW-1:0] color_q;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    if (int'(v) == NREQ - 1) return '0;
    return v + 1'b1;
  endfunction

  // The first write of a fill is issued on the accepting edge, so a start is
  // refused while the final write of a previous fill is still on the outputs.
  assign fill_go = rst && (state == IDLE) && !fill_busy && fill_start && (fill_len != '0);
  assign arb_en  = rst && (state == IDLE) && !fill_go;

  always_comb begin
    logic [PW-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  always_comb begin
    ack = '0;
    if (arb_en && grant_vld) ack[grant_idx] = 1'b1;
  end

  always_comb begin
    grant_addr = '0;
    grant_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == PW'(i)) begin
        grant_addr = req_addr[i*AW +: AW];
        grant_data = req_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      mem_px_addr <= '0;
      mem_px_data <= '0;
      px_wr       <= 1'b0;
      fill_busy   <= 1'b0;
      fill_done   <= 1'b0;
      cnt_addr    <= '0;
      remaining   <= '0;
      color_q     <= '0;
    end else begin
      px_wr     <= 1'b0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
      case (state)
        IDLE: begin
          if (fill_go) begin
            mem_px_addr <= fill_base;
            mem_px_data <= fill_color;
            px_wr       <= 1'b1;
            fill_busy   <= 1'b1;
            fill_done   <= (fill_len == AW'(1));
            cnt_addr    <= fill_base + 1'b1;
            remaining   <= fill_len - 1'b1;
            color_q     <= fill_color;
            if (fill_len != AW'(1)) state <= FILL;
          end else if (grant_vld) begin
            mem_px_addr <= grant_addr;
            mem_px_data <= grant_data;
            px_wr       <= 1'b1;
            rr_ptr      <= wrap_inc(grant_idx);
          end
        end
        FILL: begin
          mem_px_addr <= cnt_addr;
          mem_px_data <= color_q;
          px_wr       <= 1'b1;
          fill_busy   <= 1'b1;
          cnt_addr    <= cnt_addr + 1'b1;
          remaining   <= remaining - 1'b1;
          if (remaining == AW'(1)) begin
            fill_done <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter: predicted writes are queued when
// stimulus is driven and popped as px_wr strobes appear.
module tb_fb_write_arbiter;

  localparam int AW   = 15;
  localparam int DW   = 3;
  localparam int NREQ = 3;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          done;
  } wr_t;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    ack;
  logic               fill_start = 1'b0;
  logic [AW-1:0]      fill_base  = '0;
  logic [AW-1:0]      fill_len   = '0;
  logic [DW-1:0]      fill_color = '0;
  logic               fill_busy;
  logic               fill_done;
  logic [AW-1:0]      mem_px_addr;
  logic [DW-1:0]      mem_px_data;
  logic               px_wr;

  logic [AW-1:0] r_addr [NREQ];
  logic [DW-1:0] r_data [NREQ];

  wr_t exp_q[$];
  int  pass_cnt  = 0;
  int  total_cnt = 0;
  int  model_ptr = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = r_addr[i];
      req_data[i*DW +: DW] = r_data[i];
    end
  end

  fb_write_arbiter #(.AW(AW), .DW(DW), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack), .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
    .fill_color(fill_color), .fill_busy(fill_busy), .fill_done(fill_done),
    .mem_px_addr(mem_px_addr), .mem_px_data(mem_px_data), .px_wr(px_wr)
  );

  function automatic int predict(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (p + k) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic wr_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic dn);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.done = dn;
    return e;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int g);
    logic [NREQ-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    req = 3'b111;
    for (int i = 0; i < NREQ; i++) begin
      r_addr[i] = AW'(16'h0011 * (i + 1));
      r_data[i] = DW'(i + 1);
    end
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total_cnt++;
      if (ack !== 3'b000 || px_wr !== 1'b0 || mem_px_addr !== '0 || mem_px_data !== '0 ||
          fill_busy !== 1'b0 || fill_done !== 1'b0)
        $display("[TB] FAIL reset_state c=%0d: ack=%b wr=%b addr=%h data=%h busy=%b done=%b, need all zero",
                 c, ack, px_wr, mem_px_addr, mem_px_data, fill_busy, fill_done);
      else pass_cnt++;
    end
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    model_ptr = 0;
    exp_q.delete();
  endtask

  task automatic test_round_robin();
    wr_t e;
    int g;
    r_addr[0] = 15'h0100; r_data[0] = 3'd1;
    r_addr[1] = 15'h0200; r_data[1] = 3'd2;
    r_addr[2] = 15'h0300; r_data[2] = 3'd4;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c > 0) begin
        total_cnt++;
        if (exp_q.size() == 0)
          $display("[TB] FAIL rr_write c=%0d: scoreboard empty, wr=%b", c, px_wr);
        else begin
          e = exp_q.pop_front();
          if (px_wr !== 1'b1 || mem_px_addr !== e.addr || mem_px_data !== e.data || fill_done !== e.done)
            $display("[TB] FAIL rr_write c=%0d: got wr=%b addr=%h data=%h, need wr=1 addr=%h data=%h",
                     c, px_wr, mem_px_addr, mem_px_data, e.addr, e.data);
          else pass_cnt++;
        end
      end
      req = (c < 6) ? 3'b111 : 3'b000;
      #1;
      g = predict(req, model_ptr);
      total_cnt++;
      if (ack !== onehot(g))
        $display("[TB] FAIL rr_ack c=%0d: got %b need %b", c, ack, onehot(g));
      else pass_cnt++;
      if (g >= 0) begin
        exp_q.push_back(mk(r_addr[g], r_data[g], 1'b0));
        model_ptr = (g + 1) % NREQ;
      end
    end
  endtask

  task automatic test_single();
    wr_t e;
    @(negedge clk);
    r_addr[2] = 15'h2800;
    r_data[2] = 3'b111;
    req = 3'b100;
    #1;
    total_cnt++;
    if (ack !== onehot(predict(req, model_ptr)))
      $display("[TB] FAIL single_ack: got %b need %b", ack, onehot(predict(req, model_ptr)));
    else pass_cnt++;
    exp_q.push_back(mk(r_addr[2], r_data[2], 1'b0));
    model_ptr = 0;
    @(negedge clk);
    total_cnt++;
    e = exp_q.pop_front();
    if (px_wr !== 1'b1 || mem_px_addr !== e.addr || mem_px_data !== e.data)
      $display("[TB] FAIL single_write: got wr=%b addr=%h data=%h, need wr=1 addr=%h data=%h",
               px_wr, mem_px_addr, mem_px_data, e.addr, e.data);
    else pass_cnt++;
    req = '0;
    @(negedge clk);
    total_cnt++;
    if (px_wr !== 1'b0)
      $display("[TB] FAIL single_idle: got wr=%b need 0", px_wr);
    else pass_cnt++;
  endtask

  task automatic test_row_fill();
    wr_t e;
    int g;
    logic [NREQ-1:0] exp_ack;
    r_addr[0] = 15'h0555;
    r_data[0] = 3'b010;
    @(negedge clk);
    req        = 3'b001;
    fill_base  = 15'h2780;
    fill_len   = 15'd128;
    fill_color = 3'b001;
    fill_start = 1'b1;
    #1;
    total_cnt++;
    if (ack !== 3'b000) $display("[TB] FAIL fill_prio_ack: got %b need 000", ack);
    else pass_cnt++;
    for (int k = 0; k < 128; k++)
      exp_q.push_back(mk(15'h2780 + AW'(k), 3'b001, k == 127));
    for (int k = 1; k <= 129; k++) begin
      @(negedge clk);
      fill_start = 1'b0;
      total_cnt++;
      if (exp_q.size() == 0)
        $display("[TB] FAIL row_write k=%0d: scoreboard empty, wr=%b", k, px_wr);
      else begin
        e = exp_q.pop_front();
        if (px_wr !== 1'b1 || mem_px_addr !== e.addr || mem_px_data !== e.data || fill_done !== e.done)
          $display("[TB] FAIL row_write k=%0d: got wr=%b addr=%h data=%h done=%b, need wr=1 addr=%h data=%h done=%b",
                   k, px_wr, mem_px_addr, mem_px_data, fill_done, e.addr, e.data, e.done);
        else pass_cnt++;
      end
      total_cnt++;
      if (fill_busy !== (k <= 128))
        $display("[TB] FAIL row_busy k=%0d: got %b need %b", k, fill_busy, (k <= 128));
      else pass_cnt++;
      if (k == 129) req = '0;
      #1;
      g = (k >= 128) ? predict(req, model_ptr) : -1;
      exp_ack = onehot(g);
      total_cnt++;
      if (ack !== exp_ack) $display("[TB] FAIL row_ack k=%0d: got %b need %b", k, ack, exp_ack);
      else pass_cnt++;
      if (g >= 0) begin
        exp_q.push_back(mk(r_addr[g], r_data[g], 1'b0));
        model_ptr = (g + 1) % NREQ;
      end
    end
  endtask

  task automatic test_fill_corners();
    wr_t e;
    int g;
    for (int tc = 0; tc < 2; tc++) begin
      logic [AW-1:0] base;
      logic [DW-1:0] col;
      int len;
      base = (tc == 0) ? 15'h7FFE : 15'h0400;
      len  = (tc == 0) ? 3 : 6;
      col  = (tc == 0) ? 3'd5 : 3'd2;
      @(negedge clk);
      fill_base  = base;
      fill_len   = AW'(len);
      fill_color = col;
      fill_start = 1'b1;
      for (int k = 0; k < len; k++)
        exp_q.push_back(mk(base + AW'(k), col, k == len - 1));
      for (int k = 1; k <= len + 1; k++) begin
        @(negedge clk);
        fill_start = (tc == 1 && k == 2);
        if (fill_start) begin
          fill_base  = 15'h1234;
          fill_len   = 15'd4;
          fill_color = 3'd7;
        end
        total_cnt++;
        if (k <= len) begin
          e = exp_q.pop_front();
          if (px_wr !== 1'b1 || mem_px_addr !== e.addr || mem_px_data !== e.data ||
              fill_done !== e.done || fill_busy !== 1'b1)
            $display("[TB] FAIL corner_write tc=%0d k=%0d: got wr=%b addr=%h data=%h done=%b busy=%b, need wr=1 addr=%h data=%h done=%b busy=1",
                     tc, k, px_wr, mem_px_addr, mem_px_data, fill_done, fill_busy, e.addr, e.data, e.done);
          else pass_cnt++;
        end else begin
          if (px_wr !== 1'b0 || fill_busy !== 1'b0)
            $display("[TB] FAIL corner_end tc=%0d: got wr=%b busy=%b, need 0 0", tc, px_wr, fill_busy);
          else pass_cnt++;
        end
      end
    end
    // zero-length start must leave the arbiter serving requesters
    @(negedge clk);
    fill_base  = 15'h0040;
    fill_len   = '0;
    fill_color = 3'd6;
    fill_start = 1'b1;
    r_addr[1]  = 15'h0ABC;
    r_data[1]  = 3'd3;
    req        = 3'b010;
    #1;
    g = predict(req, model_ptr);
    total_cnt++;
    if (ack !== onehot(g)) $display("[TB] FAIL len0_ack: got %b need %b", ack, onehot(g));
    else pass_cnt++;
    if (g >= 0) begin
      exp_q.push_back(mk(r_addr[g], r_data[g], 1'b0));
      model_ptr = (g + 1) % NREQ;
    end
    @(negedge clk);
    fill_start = 1'b0;
    req        = '0;
    total_cnt++;
    if (exp_q.size() == 0)
      $display("[TB] FAIL len0_write: scoreboard empty, wr=%b", px_wr);
    else begin
      e = exp_q.pop_front();
      if (px_wr !== 1'b1 || mem_px_addr !== e.addr || mem_px_data !== e.data || fill_busy !== 1'b0)
        $display("[TB] FAIL len0_write: got wr=%b addr=%h data=%h busy=%b, need wr=1 addr=%h data=%h busy=0",
                 px_wr, mem_px_addr, mem_px_data, fill_busy, e.addr, e.data);
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if (px_wr !== 1'b0 || fill_busy !== 1'b0)
      $display("[TB] FAIL len0_idle: got wr=%b busy=%b, need 0 0", px_wr, fill_busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_fill();
    wr_t e;
    int g;
    @(negedge clk);
    fill_base  = 15'h3000;
    fill_len   = 15'd50;
    fill_color = 3'd6;
    fill_start = 1'b1;
    for (int k = 0; k < 50; k++)
      exp_q.push_back(mk(15'h3000 + AW'(k), 3'd6, k == 49));
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      fill_start = 1'b0;
      total_cnt++;
      e = exp_q.pop_front();
      if (px_wr !== 1'b1 || mem_px_addr !== e.addr || mem_px_data !== e.data || fill_done !== e.done)
        $display("[TB] FAIL midrst_write k=%0d: got wr=%b addr=%h data=%h done=%b, need wr=1 addr=%h data=%h done=%b",
                 k, px_wr, mem_px_addr, mem_px_data, fill_done, e.addr, e.data, e.done);
      else pass_cnt++;
    end
    rst = 1'b0;
    #1;
    total_cnt++;
    if (ack !== 3'b000) $display("[TB] FAIL midrst_ack: got %b need 000", ack);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (px_wr !== 1'b0 || fill_busy !== 1'b0 || fill_done !== 1'b0)
      $display("[TB] FAIL midrst_abort: got wr=%b busy=%b done=%b, need 0 0 0", px_wr, fill_busy, fill_done);
    else pass_cnt++;
    exp_q.delete();
    model_ptr = 0;
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      r_addr[i] = AW'(16'h4000 + i);
      r_data[i] = DW'(7 - i);
    end
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) begin
        @(negedge clk);
        total_cnt++;
        if (exp_q.size() == 0)
          $display("[TB] FAIL postrst_write c=%0d: scoreboard empty, wr=%b", c, px_wr);
        else begin
          e = exp_q.pop_front();
          if (px_wr !== 1'b1 || mem_px_addr !== e.addr || mem_px_data !== e.data || fill_busy !== 1'b0)
            $display("[TB] FAIL postrst_write c=%0d: got wr=%b addr=%h data=%h busy=%b, need wr=1 addr=%h data=%h busy=0",
                     c, px_wr, mem_px_addr, mem_px_data, fill_busy, e.addr, e.data);
          else pass_cnt++;
        end
      end
      req = (c < 3) ? 3'b111 : 3'b000;
      #1;
      g = predict(req, model_ptr);
      total_cnt++;
      if (ack !== onehot(g)) $display("[TB] FAIL postrst_ack c=%0d: got %b need %b", c, ack, onehot(g));
      else pass_cnt++;
      if (g >= 0) begin
        exp_q.push_back(mk(r_addr[g], r_data[g], 1'b0));
        model_ptr = (g + 1) % NREQ;
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      r_addr[i] = '0;
      r_data[i] = '0;
    end
    test_reset();
    test_round_robin();
    test_single();
    test_row_fill();
    test_fill_corners();
    test_reset_mid_fill();
    total_cnt++;
    if (exp_q.size() != 0) $display("[TB] FAIL scoreboard_drain: %0d writes outstanding, need 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
